// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
//   Shared constants and types for the 320x240x8 framebuffer access path.
//   Geometry, bus widths, write-queue entry layout and the arbiter FSM
//   state encoding live here so the interface, FIFO and arbiter agree.
//   Optional feature macro used by the arbiter: FB_CLEAR_EN.
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_W          = 320;
  localparam int FB_H          = 240;
  localparam int FB_PIXELS     = FB_W * FB_H;   // 76800
  localparam int ADDR_W        = 17;
  localparam int DATA_W        = 8;
  localparam int WR_FIFO_DEPTH = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // One queued pixel write.
  typedef struct packed {
    addr_t addr;
    data_t data;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_WAIT = 2'd1,
    CLEAR    = 2'd2
  } fb_state_e;

  // True when the address maps onto a real pixel.
  function automatic logic addr_in_range(input addr_t a);
    return 32'(a) < FB_PIXELS;
  endfunction

endpackage

// File: rtl/fb_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_access_arbiter_if
//   Bundles the display-read, pixel-write, clear-control and BRAM port
//   signals of the framebuffer arbiter.
//   Modports:
//     slave  - the arbiter's view (consumes requests, drives the BRAM port)
//     master - the surrounding system's view (display, drawing logic, BRAM)
// -----------------------------------------------------------------------------
interface fb_access_arbiter_if;
  import fb_pkg::*;

  // display scan-out read
  logic  disp_req;
  addr_t disp_addr;
  data_t disp_data;
  logic  disp_valid;
  // pixel writer
  logic  wr_valid;
  logic  wr_ready;
  addr_t wr_addr;
  data_t wr_data;
  logic  wr_oob;
  // clear engine control
  logic  clr_start;
  data_t clr_color;
  logic  clr_busy;
  // single BRAM port
  addr_t mem_addr;
  logic  mem_we;
  data_t mem_wdata;
  data_t mem_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    output disp_data, disp_valid, wr_ready, wr_oob, clr_busy,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    input  disp_data, disp_valid, wr_ready, wr_oob, clr_busy,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
//   Synchronous FIFO of {addr,data} pixel writes.
//   Ports:
//     clk, rst    clock, synchronous active-high reset (empties the queue)
//     push, din   enqueue din (caller guarantees !full)
//     pop, head   dequeue; head is the current oldest entry
//     full, empty occupancy flags
//   DEPTH must be a power of two >= 2.
// -----------------------------------------------------------------------------
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = WR_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wr_req_t din,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0] wr_ptr, rd_ptr;
  wr_req_t        mem [DEPTH];

  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // NOTE: storage is not reset; validity is tracked by the pointers alone,
  // which keeps the array mappable to plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/fb_access_arbiter.sv
// -----------------------------------------------------------------------------
// fb_access_arbiter
//   Owns the single port of the 320x240x8 framebuffer BRAM. Display reads
//   always win the port; pixel writes wait in a small FIFO and drain on
//   cycles the display leaves idle. Writes to addresses past the last pixel
//   are consumed without touching memory and flagged on wr_oob.
//   Optional full-screen clear engine enabled by the macro FB_CLEAR_EN.
//   Ports:
//     clk    pixel clock
//     rst    synchronous active-high reset
//     bus    fb_access_arbiter_if.slave: disp_* read port, wr_* write port,
//            clr_* clear control, mem_* BRAM port (1-cycle read latency)
// -----------------------------------------------------------------------------
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int WR_FIFO_DEPTH = fb_pkg::WR_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  fb_access_arbiter_if.slave  bus
);

  fb_state_e state_q, state_d;
  wr_req_t   head;
  logic      fifo_full, fifo_empty;
  logic      push, pop, wr_ready;
  logic      rd_pend_q, disp_valid_q;
  data_t     disp_data_q;
  addr_t     mem_addr;
  logic      mem_we;
  data_t     mem_wdata;
  logic      wr_oob;

  // New writes are refused while a clear is pending so none slip in between.
  assign wr_ready = !rst && !fifo_full && (state_q == IDLE);
  assign push     = bus.wr_valid && wr_ready;

  fb_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ('{addr: bus.wr_addr, data: bus.wr_data}),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FB_CLEAR_EN
  localparam addr_t CLR_LAST = ADDR_W'(FB_PIXELS - 1);
  addr_t clr_cnt_q;
  data_t clr_color_q;
  logic  clr_wr;
`endif

  // Port select: display read > clear write > FIFO head.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    pop       = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_oob    = 1'b0;
`ifdef FB_CLEAR_EN
    clr_wr    = 1'b0;
`endif
    if (!rst) begin
      if (bus.disp_req) begin
        mem_addr = bus.disp_addr;
`ifdef FB_CLEAR_EN
      end else if (state_q == CLEAR) begin
        mem_addr  = clr_cnt_q;
        mem_we    = 1'b1;
        mem_wdata = clr_color_q;
        clr_wr    = 1'b1;
`endif
      end else if (!fifo_empty) begin
        // Out-of-range entries are still popped so the queue keeps moving.
        pop       = 1'b1;
        mem_addr  = head.addr;
        mem_wdata = head.data;
        mem_we    = addr_in_range(head.addr);
        wr_oob    = !addr_in_range(head.addr);
      end
    end

`ifdef FB_CLEAR_EN
    unique case (state_q)
      IDLE:     if (bus.clr_start) state_d = CLR_WAIT;
      CLR_WAIT: if (fifo_empty)    state_d = CLEAR;
      CLEAR:    if (clr_wr && clr_cnt_q == CLR_LAST) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_pend_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      // BRAM data arrives one cycle after the address; register it once more.
      rd_pend_q    <= bus.disp_req;
      disp_valid_q <= rd_pend_q;
      if (rd_pend_q) disp_data_q <= bus.mem_rdata;
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
    end else begin
      if (state_q == IDLE && bus.clr_start) clr_color_q <= bus.clr_color;
      // The counter only moves on cycles the clear actually owned the port.
      if (clr_wr) clr_cnt_q <= (clr_cnt_q == CLR_LAST) ? '0 : clr_cnt_q + ADDR_W'(1);
    end
  end

  assign bus.clr_busy = (state_q != IDLE);
`else
  logic unused_clr;
  assign unused_clr   = ^{bus.clr_start, bus.clr_color};
  assign bus.clr_busy = 1'b0;
`endif

  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.wr_ready   = wr_ready;
  assign bus.wr_oob     = wr_oob;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_we     = mem_we;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_access_arbiter
//   Directed bench for fb_access_arbiter. A registered BRAM model returns
//   pat(addr) one cycle after the address. Expected read data and expected
//   memory writes are queued when stimulus is driven and popped by a monitor
//   on every disp_valid / mem_we; wr_oob pulses are matched against a count
//   of accepted out-of-range writes. Clear test depends on FB_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_fb_access_arbiter;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_access_arbiter_if bus ();

  fb_access_arbiter #(.WR_FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  rd_q[$];
  logic [24:0] wr_q[$];
  int          oob_exp = 0;
  logic [7:0]  mon_rd;
  logic [24:0] mon_wr;

  // Read-back pattern; pat(100) = 0xA5.
  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ 8'hC1;
  endfunction

  // Registered single-port BRAM model.
  always @(posedge clk) bus.mem_rdata <= pat(bus.mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.disp_valid === 1'b1) begin
        check("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          mon_rd = rd_q.pop_front();
          check("rd_data", bus.disp_data, mon_rd);
        end
      end
      if (bus.mem_we === 1'b1) begin
        check("we_while_disp_req", bus.disp_req, 0);
        check("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          mon_wr = wr_q.pop_front();
          check("wr_addr", bus.mem_addr, mon_wr[24:8]);
          check("wr_data", bus.mem_wdata, mon_wr[7:0]);
        end
      end
      if (bus.wr_oob === 1'b1) begin
        check("oob_expected", oob_exp > 0, 1);
        if (oob_exp > 0) oob_exp--;
      end
    end
  end

  // One clock cycle of stimulus, entered and left 1 time unit after posedge.
  task automatic cycle(input logic rq, input logic [16:0] ra,
                       input logic wv, input logic [16:0] wa, input logic [7:0] wd,
                       output logic acc, output logic we, output logic oob);
    bus.disp_req  = rq;
    bus.disp_addr = ra;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    @(negedge clk);
    acc = wv && (bus.wr_ready === 1'b1);
    we  = bus.mem_we;
    oob = bus.wr_oob;
    if (rq) rd_q.push_back(pat(ra));
    if (acc) begin
      if (wa < 17'(FB_PIXELS)) wr_q.push_back({wa, wd});
      else                     oob_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  logic acc, we, oob;
  int   idx, we_cnt, we_win;
  logic done;

  initial begin
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;
    bus.clr_color = '0;

    // ---- reset ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_disp_data",  bus.disp_data,  0);
    check("rst_wr_oob",     bus.wr_oob,     0);
    check("rst_clr_busy",   bus.clr_busy,   0);
    check("rst_mem_we",     bus.mem_we,     0);
    check("rst_mem_addr",   bus.mem_addr,   0);
    check("rst_mem_wdata",  bus.mem_wdata,  0);
    check("rst_wr_ready",   bus.wr_ready,   0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("wr_ready_after_rst", bus.wr_ready, 1);
    @(posedge clk);
    #1;

    // ---- read latency ----
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'd100;
    @(negedge clk);
    check("lat_mem_addr", bus.mem_addr, 100);
    rd_q.push_back(8'hA5);
    @(posedge clk);
    #1 bus.disp_req = 1'b0;
    @(negedge clk);
    check("lat_valid_t1", bus.disp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid_t2", bus.disp_valid, 1);
    check("lat_data_t2",  bus.disp_data,  8'hA5);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid_t3", bus.disp_valid, 0);
    @(posedge clk);
    #1;

    // ---- priority: display holds the port, FIFO fills ----
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 17'(200 + i), 1'b1, 17'(500 + i), 8'(8'h40 + i), acc, we, oob);
      check($sformatf("prio_accept%0d", i), acc, (i < 4) ? 1 : 0);
      check($sformatf("prio_no_we%0d", i), we, 0);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 1'b0, '0, '0, acc, we, oob);
      check($sformatf("prio_drain_we%0d", k), we, 1);
    end
    cycle(1'b0, '0, 1'b0, '0, '0, acc, we, oob);
    check("prio_drain_done", we, 0);

    // ---- interleave: read every other cycle, stream 100 writes ----
    idx    = 0;
    we_cnt = 0;
    we_win = 0;
    for (int c = 0; c < 210; c++) begin
      cycle(c % 2 == 0, 17'(3000 + c), idx < 100, 17'(1000 + idx), 8'(idx * 3), acc, we, oob);
      if (acc) idx++;
      if (we) begin
        we_cnt++;
        if (c >= 10 && c < 110) we_win++;
      end
    end
    check("ilv_accepted", idx, 100);
    check("ilv_writes", we_cnt, 100);
    check("ilv_rate", we_win, 50);

    // ---- out-of-range write ----
    cycle(1'b0, '0, 1'b1, 17'd76800, 8'h11, acc, we, oob);
    check("oob_accept", acc, 1);
    cycle(1'b0, '0, 1'b1, 17'd76799, 8'h22, acc, we, oob);
    check("oob_pulse", oob, 1);
    check("oob_no_we", we, 0);
    check("oob_next_accept", acc, 1);
    cycle(1'b0, '0, 1'b0, '0, '0, acc, we, oob);
    check("oob_next_we", we, 1);
    check("oob_single_pulse", oob, 0);

`ifdef FB_CLEAR_EN
    // ---- clear engine: queued writes first, then the whole screen ----
    cycle(1'b1, 17'd10, 1'b1, 17'd20, 8'h01, acc, we, oob);
    check("clr_q0_accept", acc, 1);
    cycle(1'b1, 17'd11, 1'b1, 17'd21, 8'h02, acc, we, oob);
    check("clr_q1_accept", acc, 1);
    bus.clr_start = 1'b1;
    bus.clr_color = 8'h3C;
    cycle(1'b1, 17'd12, 1'b0, '0, '0, acc, we, oob);
    bus.clr_start = 1'b0;
    bus.clr_color = 8'h00;
    check("clr_busy_rise", bus.clr_busy, 1);
    for (int j = 0; j < FB_PIXELS; j++) wr_q.push_back({17'(j), 8'h3C});
    done = 1'b0;
    for (int n = 0; n < 80000 && !done; n++) begin
      cycle((n < 40) && (n % 2 == 0), 17'(n), 1'b0, '0, '0, acc, we, oob);
      if (bus.clr_busy === 1'b0) done = 1'b1;
    end
    check("clr_busy_fall", done, 1);
    check("clr_writes_left", wr_q.size(), 0);
`else
    // ---- clear engine absent: request is ignored ----
    bus.clr_start = 1'b1;
    bus.clr_color = 8'h3C;
    for (int n = 0; n < 6; n++) begin
      cycle(1'b0, '0, 1'b0, '0, '0, acc, we, oob);
      bus.clr_start = 1'b0;
      check($sformatf("clr_busy_tied%0d", n), bus.clr_busy, 0);
      check($sformatf("clr_no_we%0d", n), we, 0);
    end
`endif

    // ---- reset with a read in flight ----
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'd7;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.disp_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("rst_inflight_valid", bus.disp_valid, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("post_rst_valid", bus.disp_valid, 0);
      check("post_rst_ready", bus.wr_ready, 1);
      @(posedge clk);
      #1;
    end

    check("final_rd_q_empty", rd_q.size(), 0);
    check("final_wr_q_empty", wr_q.size(), 0);
    check("final_oob_matched", oob_exp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
